// File: rtl/bkm_pkg.sv
// Shared definitions for the BKM step sequencing logic: FSM encoding, mode
// encoding, default iteration/latency settings and a width helper.
package bkm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } bkm_state_e;

  localparam logic MODE_E = 1'b0;
  localparam logic MODE_L = 1'b1;

  localparam int BKM_N_STEPS  = 32;
  localparam int BKM_STEP_LAT = 1;

  // Smallest r with 2**r >= v (returns 0 for v <= 1).
  function automatic int bkm_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/bkm_step_wait_cnt.sv
// Loadable down-counter used to space out datapath steps; saturates at zero
// and exposes the live count plus a zero flag.
module bkm_step_wait_cnt
  import bkm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (!srst) begin
      cnt <= '0;
    end else if (en) begin
      if (load) begin
        cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
        cnt <= cnt - W'(1);
      end
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bkm_step_sequencer.sv
// Sequences one shared bkm_step datapath through N_STEPS iterations of a BKM
// evaluation and hands the finished result downstream via valid/ready.
module bkm_step_sequencer
  import bkm_pkg::*;
#(
  parameter int N_STEPS  = BKM_N_STEPS,
  parameter int STEP_LAT = BKM_STEP_LAT,
  parameter int N_W      = 6
) (
  input  logic           clk,
  input  logic           srst,
  input  logic           enable,
  input  logic           start,
  input  logic           mode_in,
  input  logic           abort,
  output logic           busy,
  output logic           step_load,
  output logic           step_en,
  output logic [N_W-1:0] step_n,
  output logic           step_mode,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int CNT_W = (bkm_clog2(STEP_LAT + 1) < 1) ? 1 : bkm_clog2(STEP_LAT + 1);
  localparam logic [N_W-1:0]   LAST_N    = N_W'(N_STEPS - 1);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(STEP_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  bkm_state_e       state, state_nxt;
  logic [N_W-1:0]   step_n_nxt;
  logic             mode_nxt;
  logic             cnt_load, cnt_dec;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_zero;
  logic             wait_last;
  logic             last_step;

  bkm_step_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .srst     (srst),
    .en       (enable),
    .load     (cnt_load),
    .load_val (WAIT_INIT),
    .dec      (cnt_dec),
    .cnt      (wait_cnt),
    .zero     (wait_zero)
  );

  // The count is sampled before its own decrement, so a value of one means
  // this WAIT cycle is the last one of the step.
  assign wait_last = wait_zero || (wait_cnt == CNT_ONE);
  assign last_step = (step_n == LAST_N);

  always_comb begin
    state_nxt  = state;
    step_n_nxt = step_n;
    mode_nxt   = step_mode;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt  = ST_LOAD;
          step_n_nxt = '0;
          mode_nxt   = mode_in;
        end
      end
      ST_LOAD: state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        cnt_load = 1'b1;
        if (STEP_LAT > 1) begin
          state_nxt = ST_WAIT;
        end else if (last_step) begin
          state_nxt = ST_DONE;
        end else begin
          step_n_nxt = step_n + N_W'(1);
          state_nxt  = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        cnt_dec = 1'b1;
        if (wait_last) begin
          if (last_step) begin
            state_nxt = ST_DONE;
          end else begin
            step_n_nxt = step_n + N_W'(1);
            state_nxt  = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Abort beats every other transition outside IDLE, including delivery.
    if (abort && (state != ST_IDLE)) begin
      state_nxt  = ST_IDLE;
      step_n_nxt = step_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst) begin
      state     <= ST_IDLE;
      step_n    <= '0;
      step_mode <= MODE_E;
    end else if (enable) begin
      state     <= state_nxt;
      step_n    <= step_n_nxt;
      step_mode <= mode_nxt;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign step_load = (state == ST_LOAD);
  assign step_en   = (state == ST_ISSUE);
  assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_bkm_step_sequencer.sv
// Directed bench for bkm_step_sequencer: two instances (defaults, and
// STEP_LAT=3/N_STEPS=4) checked every cycle against an elapsed-time model.
module tb_bkm_step_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst;
  logic a_en, a_start, a_mode, a_abort, a_ready;
  logic a_busy, a_load, a_sen, a_smode, a_ov;
  logic [5:0] a_n;
  logic b_en, b_start, b_mode, b_abort, b_ready;
  logic b_busy, b_load, b_sen, b_smode, b_ov;
  logic [5:0] b_n;

  bkm_step_sequencer #(.N_STEPS(32), .STEP_LAT(1), .N_W(6)) dut_a (
    .clk(clk), .srst(srst), .enable(a_en), .start(a_start), .mode_in(a_mode),
    .abort(a_abort), .busy(a_busy), .step_load(a_load), .step_en(a_sen),
    .step_n(a_n), .step_mode(a_smode), .out_valid(a_ov), .out_ready(a_ready)
  );

  bkm_step_sequencer #(.N_STEPS(4), .STEP_LAT(3), .N_W(6)) dut_b (
    .clk(clk), .srst(srst), .enable(b_en), .start(b_start), .mode_in(b_mode),
    .abort(b_abort), .busy(b_busy), .step_load(b_load), .step_en(b_sen),
    .step_n(b_n), .step_mode(b_smode), .out_valid(b_ov), .out_ready(b_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Model: an evaluation is described by the number of enabled cycles t
  // since its start was accepted (t=1 is the load cycle).
  int m_busy [2];
  int m_t    [2];
  int m_n    [2];
  int m_mode [2];
  bit m_live = 1'b0;

  task automatic mstep(input int d, input logic en, input logic st, input logic md,
                       input logic ab, input logic rdy, input int N, input int L);
    if (!srst) begin
      m_busy[d] = 0; m_t[d] = 0; m_n[d] = 0; m_mode[d] = 0;
    end else if (en) begin
      if (m_busy[d] == 0) begin
        if (st) begin
          m_busy[d] = 1; m_t[d] = 1; m_n[d] = 0; m_mode[d] = int'(md);
        end
      end else if (ab) begin
        m_busy[d] = 0;
      end else if (m_t[d] >= 2 + N * L) begin
        if (rdy) m_busy[d] = 0;
      end else begin
        m_t[d] = m_t[d] + 1;
        if (m_t[d] >= 2) m_n[d] = ((m_t[d] - 2) / L < N - 1) ? (m_t[d] - 2) / L : N - 1;
      end
    end
  endtask

  task automatic mcmp(input int d, input string p, input int N, input int L,
                      input logic busy, input logic ld, input logic en,
                      input logic [5:0] n, input logic md, input logic ov);
    int t;
    logic e_ld, e_en, e_ov;
    t    = m_t[d];
    e_ld = (m_busy[d] != 0) && (t == 1);
    e_en = (m_busy[d] != 0) && (t >= 2) && (t < 2 + N * L) && (((t - 2) % L) == 0);
    e_ov = (m_busy[d] != 0) && (t >= 2 + N * L);
    chk({p, "_busy"}, 32'(busy), 32'(m_busy[d]));
    chk({p, "_step_load"}, 32'(ld), 32'(e_ld));
    chk({p, "_step_en"}, 32'(en), 32'(e_en));
    chk({p, "_step_n"}, 32'(n), 32'(m_n[d]));
    chk({p, "_step_mode"}, 32'(md), 32'(m_mode[d]));
    chk({p, "_out_valid"}, 32'(ov), 32'(e_ov));
  endtask

  always @(posedge clk) begin
    mstep(0, a_en, a_start, a_mode, a_abort, a_ready, 32, 1);
    mstep(1, b_en, b_start, b_mode, b_abort, b_ready, 4, 3);
    m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      mcmp(0, "a", 32, 1, a_busy, a_load, a_sen, a_n, a_smode, a_ov);
      mcmp(1, "b", 4, 3, b_busy, b_load, b_sen, b_n, b_smode, b_ov);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] enmask;

  initial begin
    srst = 1'b0;
    a_en = 1'b1; a_start = 1'b0; a_mode = 1'b0; a_abort = 1'b0; a_ready = 1'b0;
    b_en = 1'b1; b_start = 1'b0; b_mode = 1'b0; b_abort = 1'b0; b_ready = 1'b0;
    tick(2);
    chk("rst_a_busy", 32'(a_busy), 0);
    chk("rst_a_step_n", 32'(a_n), 0);
    chk("rst_b_out_valid", 32'(b_ov), 0);
    chk("rst_b_step_en", 32'(b_sen), 0);
    srst = 1'b1;
    tick(1);

    // Nominal E-mode plus backpressure in DONE with an ignored start
    a_start = 1'b1; a_mode = 1'b0;
    tick(); a_start = 1'b0;
    chk("t1_load_c1", 32'(a_load), 1);
    for (int k = 2; k <= 33; k++) begin
      tick();
      chk("t1_en", 32'(a_sen), 1);
      chk("t1_n", 32'(a_n), 32'(k - 2));
    end
    tick();
    chk("t1_ov_c34", 32'(a_ov), 1);
    chk("t1_n_final", 32'(a_n), 31);
    for (int k = 35; k <= 44; k++) begin
      tick();
      chk("t1_bp_ov", 32'(a_ov), 1);
      chk("t1_bp_n", 32'(a_n), 31);
      a_start = (k == 37);
    end
    a_start = 1'b0;
    a_ready = 1'b1;
    tick(); a_ready = 1'b0;
    chk("t1_rel_busy", 32'(a_busy), 0);
    chk("t1_rel_ov", 32'(a_ov), 0);
    tick();
    chk("t1_no_queued_start", 32'(a_load), 0);

    // STEP_LAT=3, N_STEPS=4, L-mode
    b_start = 1'b1; b_mode = 1'b1;
    tick(); b_start = 1'b0; b_mode = 1'b0;
    enmask = '0;
    for (int c = 1; c <= 14; c++) begin
      if (b_sen) enmask[c] = 1'b1;
      chk("t2_mode", 32'(b_smode), 1);
      chk("t2_ov", 32'(b_ov), (c == 14) ? 32'd1 : 32'd0);
      if (c < 14) tick();
    end
    chk("t2_en_cycles", enmask, 32'h0000_0924);
    chk("t2_n_final", 32'(b_n), 3);
    b_ready = 1'b1;
    tick(); b_ready = 1'b0;
    chk("t2_rel_busy", 32'(b_busy), 0);

    // Abort in WAIT, restart, abort in ISSUE, start+abort in IDLE, abort+ready in DONE
    b_start = 1'b1;
    tick(); b_start = 1'b0;
    tick(5);
    chk("t3_wait_no_en", 32'(b_sen), 0);
    b_abort = 1'b1;
    tick(); b_abort = 1'b0;
    chk("t3_abort_busy", 32'(b_busy), 0);
    chk("t3_abort_en", 32'(b_sen), 0);
    b_start = 1'b1;
    tick(); b_start = 1'b0;
    chk("t3_restart_load", 32'(b_load), 1);
    tick();
    chk("t3_restart_en", 32'(b_sen), 1);
    chk("t3_restart_n", 32'(b_n), 0);
    b_abort = 1'b1;
    tick(); b_abort = 1'b0;
    chk("t3_abort_issue_busy", 32'(b_busy), 0);
    b_start = 1'b1; b_abort = 1'b1;
    tick(); b_start = 1'b0; b_abort = 1'b0;
    chk("t3_start_wins", 32'(b_load), 1);
    tick(13);
    chk("t3_ov_c14", 32'(b_ov), 1);
    b_abort = 1'b1; b_ready = 1'b1;
    tick(); b_abort = 1'b0; b_ready = 1'b0;
    chk("t3_abort_done_busy", 32'(b_busy), 0);
    chk("t3_abort_done_ov", 32'(b_ov), 0);

    // enable held low for 5 cycles while issuing step 7
    a_start = 1'b1; a_mode = 1'b1;
    tick(); a_start = 1'b0; a_mode = 1'b0;
    tick(8);
    chk("t4_en_c9", 32'(a_sen), 1);
    chk("t4_n_c9", 32'(a_n), 7);
    a_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_hold_en", 32'(a_sen), 1);
      chk("t4_hold_n", 32'(a_n), 7);
    end
    a_en = 1'b1;
    tick();
    chk("t4_resume_n", 32'(a_n), 8);
    tick(23);
    chk("t4_ov_c38", 32'(a_ov), 0);
    tick();
    chk("t4_ov_c39", 32'(a_ov), 1);
    a_ready = 1'b1;
    tick(); a_ready = 1'b0;
    chk("t4_rel_busy", 32'(a_busy), 0);

    // Mid-run reset, then start in the first released cycle
    a_start = 1'b1; a_mode = 1'b1;
    tick(); a_start = 1'b0;
    tick(9);
    srst = 1'b0;
    tick(); srst = 1'b1;
    chk("t5_busy", 32'(a_busy), 0);
    chk("t5_load", 32'(a_load), 0);
    chk("t5_en", 32'(a_sen), 0);
    chk("t5_n", 32'(a_n), 0);
    chk("t5_mode", 32'(a_smode), 0);
    chk("t5_ov", 32'(a_ov), 0);
    a_start = 1'b1; a_mode = 1'b1;
    tick(); a_start = 1'b0; a_mode = 1'b0;
    chk("t5_restart_load", 32'(a_load), 1);
    chk("t5_restart_mode", 32'(a_smode), 1);
    tick(33);
    chk("t5_ov", 32'(a_ov), 1);
    a_ready = 1'b1;
    tick(); a_ready = 1'b0;
    chk("t5_rel_busy", 32'(a_busy), 0);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
